// File: rtl/display_scan_bcd.sv
// display_scan_bcd
// Binary-to-BCD converter (shift-and-add-3) feeding a multiplexed,
// active-low 7-segment display scanner with a decimal-point halt indicator.
// The busy output is registered. It asserts on the edge that accepts a
// strobe and drops one edge after the FSM returns to IDLE. With no pending
// value, busy is high for DATA_WIDTH+2 cycles.
// seg and dig are computed from next-state values and registered together,
// so a committed value is visible on the same edge that commits it.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant nonzero digit. Digit 0 is never blanked.
module display_scan_bcd #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REFRESH_DIV = 208333
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ValorSaida,
  input  logic                  EnableOut,
  input  logic                  halt,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // Converter state
  logic [1:0]            state_q,   state_d;
  logic [DATA_WIDTH-1:0] sr_q,      sr_d;
  logic [BCD_W-1:0]      bcd_q,     bcd_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic [DATA_WIDTH-1:0] pend_q,    pend_d;
  logic                  pend_v_q,  pend_v_d;

  // Committed display value
  logic [BCD_W-1:0]      digits_q,  digits_d;
  logic                  ovf_q,     ovf_d;
  logic                  busy_q,    busy_d;

  // Scanner state
  logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [7:0]            seg_q,     seg_d;
  logic [NUM_DIGITS-1:0] dig_q,     dig_d;

  // Helpers
  logic [BCD_W-1:0]      bcd_adj;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_val;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic [IDX_W-1:0]      msd_idx;
  logic [6:0]            seg7;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction of every BCD digit that is 5 or more
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: converter FSM, pending slot, commit, reset override
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    ovf_acc_d = ovf_acc_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    busy_d    = 1'b0;
    ref_cnt_d = ref_cnt_q;
    idx_d     = idx_q;
    load      = 1'b0;
    load_val  = ValorSaida;

    case (state_q)
      IDLE: begin
        if (EnableOut) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (EnableOut) begin
          pend_d   = ValorSaida;
          pend_v_d = 1'b1;
        end
        // The top bit of the corrected accumulator leaves the display range
        ovf_acc_d = ovf_acc_q | bcd_adj[BCD_W-1];
        bcd_d     = {bcd_adj[BCD_W-2:0], sr_q[DATA_WIDTH-1]};
        sr_d      = {sr_q[DATA_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        digits_d = bcd_q;
        ovf_d    = ovf_acc_q;
        state_d  = IDLE;
        // A strobe in this cycle is the newest pending value
        if (EnableOut) begin
          load     = 1'b1;
          pend_v_d = 1'b0;
        end else if (pend_v_q) begin
          load     = 1'b1;
          load_val = pend_q;
          pend_v_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sr_d      = load_val;
      bcd_d     = '0;
      bit_cnt_d = '0;
      ovf_acc_d = 1'b0;
      state_d   = SHIFT;
    end

    busy_d = load | (state_q != IDLE);

    // Refresh divider and scan index
    if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
    end

    if (reset) begin
      state_d   = IDLE;
      sr_d      = '0;
      bcd_d     = '0;
      bit_cnt_d = '0;
      ovf_acc_d = 1'b0;
      pend_d    = '0;
      pend_v_d  = 1'b0;
      ovf_d     = 1'b0;
      busy_d    = 1'b0;
      ref_cnt_d = '0;
      idx_d     = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        digits_d[4*k +: 4] = 4'((k + 1) % 10);
      end
    end
  end

  // Segment/digit drive computed from next-state values
  always_comb begin
    cur_digit = 4'd0;
    msd_idx   = '0;
    blank     = 1'b0;
    seg7      = 7'b1111111;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx_d) begin
        cur_digit = digits_d[4*k +: 4];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      if (digits_d[4*k +: 4] != 4'd0) begin
        msd_idx = IDX_W'(k);
      end
    end
    blank = (idx_d > msd_idx);
`else
    blank = 1'b0;
`endif
    if (ovf_d) begin
      seg7 = 7'b0111111;
    end else if (blank) begin
      seg7 = 7'b1111111;
    end else begin
      seg7 = seg_decode(cur_digit);
    end
    seg_d = {~halt, seg7};
    dig_d = ~(NUM_DIGITS'(1) << idx_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    sr_q      <= sr_d;
    bcd_q     <= bcd_d;
    bit_cnt_q <= bit_cnt_d;
    ovf_acc_q <= ovf_acc_d;
    pend_q    <= pend_d;
    pend_v_q  <= pend_v_d;
    digits_q  <= digits_d;
    ovf_q     <= ovf_d;
    busy_q    <= busy_d;
    ref_cnt_q <= ref_cnt_d;
    idx_q     <= idx_d;
    seg_q     <= seg_d;
    dig_q     <= dig_d;
  end

  assign seg      = seg_q;
  assign dig      = dig_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: doc/display_scan_bcd.md
DISPLAY_SCAN_BCD -- requirements
Module: display_scan_bcd

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed 7-segment digits (range 1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the binary input value (range 4..32).
REQ-003 SHALL have parameter REFRESH_DIV, default 208333, clk cycles per digit slot (must be >= 2).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port ValorSaida  input  DATA_WIDTH  unsigned binary value to display.
REQ-007 SHALL have port EnableOut  input  1  single-cycle strobe: capture ValorSaida.
REQ-008 SHALL have port halt  input  1  CPU halted indicator.
REQ-009 SHALL have port seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port dig  output  NUM_DIGITS  active-low digit enables, bit k = digit k (k=0 least significant).
REQ-011 SHALL have port busy  output  1  conversion in progress.
REQ-012 SHALL have port overflow  output  1  last committed value >= 10^NUM_DIGITS.

Function
REQ-013 FSM states IDLE, SHIFT, COMMIT; busy SHALL be 1 in SHIFT and COMMIT, 0 in IDLE.
REQ-014 IDLE with EnableOut=1: load ValorSaida into shift register, clear BCD accumulator and bit counter, next state SHIFT.
REQ-015 SHIFT: each cycle, add 3 to every BCD digit >=5, then shift {BCD,shift reg} left 1; exactly DATA_WIDTH cycles, then COMMIT.
REQ-016 A 1 shifted out of the top BCD digit in any SHIFT cycle SHALL set an internal overflow flag for this conversion.
REQ-017 COMMIT (one cycle): digit registers and overflow output updated atomically from accumulator/flag; next state IDLE, or SHIFT if pending valid.
REQ-018 Latency: EnableOut sampled at edge t -> new digits/overflow visible after edge t+DATA_WIDTH+1; busy falls after edge t+DATA_WIDTH+2 when no pending.
REQ-019 EnableOut while busy SHALL store ValorSaida in a one-deep pending register (newest wins, earlier pending dropped); pending consumed at COMMIT.
REQ-020 EnableOut in the COMMIT cycle SHALL be treated as pending (not lost).
REQ-021 Refresh counter counts 0..REFRESH_DIV-1 then wraps; on wrap, scan index increments, wrapping NUM_DIGITS-1 -> 0.
REQ-022 dig SHALL be all-ones except bit[scan index]=0; exactly one digit active at any time after reset.
REQ-023 seg[6:0] SHALL decode the active digit register: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 overflow=1 SHALL force seg[6:0]=0111111 (dash) on every digit.
REQ-025 seg[7] (dp) SHALL be 0 (lit) on every digit while halt=1, else 1; halt SHALL not affect conversion.
REQ-026 seg and dig SHALL be registered outputs, changing on the same edge (no glitch between digit switch and segment update).

Reset
REQ-027 reset=1 SHALL force: FSM IDLE, busy=0, pending cleared, overflow=0, refresh counter 0, scan index 0, dig = ~1 (digit 0 active).
REQ-028 Reset digit registers SHALL hold digit k = (k+1) mod 10 (power-on pattern "...4321" read digit 0 up).
REQ-029 reset during SHIFT or COMMIT SHALL abort conversion; no partial value committed; EnableOut in the reset cycle ignored.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit SHALL show seg[6:0]=1111111; digit 0 never blanked; dp per REQ-025 still applies.
REQ-031 Macro LEADING_ZERO_BLANK_EN undefined: all digits show their decoded value, leading zeros included.

Verification (bench: NUM_DIGITS=4, DATA_WIDTH=16, REFRESH_DIV=4)
REQ-032 Reset release, no strobe -> dig cycles 1110,1101,1011,0111 every 4 clks; seg per digit = "1","2","3","4"; busy=0.
REQ-033 EnableOut with 1234 -> busy=1 for 18 cycles; after commit digit0..3 = 4,3,2,1 segs 0011001,0110000,0100100,1111001; overflow=0.
REQ-034 EnableOut 10000 then done -> overflow=1, all digits seg[6:0]=0111111; then EnableOut 9999 -> overflow=0, all digits 0010000.
REQ-035 EnableOut 11, then during busy 22 then 33 -> committed 11, then exactly one further conversion showing 33; 22 never displayed.
REQ-036 EnableOut 7 with LEADING_ZERO_BLANK_EN -> digit0=1111000, digits1..3=1111111; without macro digits1..3=1000000; halt=1 -> seg[7]=0 on all digits.
REQ-037 reset asserted at SHIFT cycle 5 of value 5555 -> after release digits show reset pattern, busy=0, no 5555 ever displayed.
